// File: rtl/memref_wr_monitor_if.sv
// Bus bundle between a kernel's memref write port / dump sink and the write monitor.
//
// Write port: p0_wr_en qualifies p0_addr_data/p0_wr_data for exactly one clock;
// there is no back-pressure, the monitor must take every strobe.
//
// Dump port (valid/ready): a beat transfers on any rising edge where
// dump_valid && dump_ready. While dump_valid is high and the beat has not
// transferred, dump_addr/dump_data/dump_last are held constant and dump_valid
// is not withdrawn. dump_ready may toggle freely and is never a precondition
// for dump_valid.
interface memref_wr_monitor_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) ();
    logic              p0_wr_en;
    logic [ADDR_W-1:0] p0_addr_data;
    logic [WIDTH-1:0]  p0_wr_data;

    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_last;

    // Kernel side / dump sink side
    modport master (
        output p0_wr_en, p0_addr_data, p0_wr_data, dump_start, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_last
    );

    // Monitor side
    modport slave (
        input  p0_wr_en, p0_addr_data, p0_wr_data, dump_start, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_last
    );
endinterface

// File: rtl/memref_wr_monitor.sv
// Memref write monitor: snoops a kernel's write port into a shadow memory,
// tracks written addresses in a bitmap, flags protocol errors, and on request
// streams the captured image out in address order over a valid/ready port.
module memref_wr_monitor #(
    parameter int WIDTH  = 32,
    parameter int SIZE   = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    memref_wr_monitor_if.slave   bus,
    output logic                 done,
    output logic [ADDR_W:0]      wr_count,
    output logic                 dup_err,
    output logic                 oob_err,
    output logic                 late_err,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        CAPTURE  = 2'd0,
        DUMP     = 2'd1,
        FINISHED = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   SIZE_L    = (ADDR_W+1)'(SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

    state_t            state;

    // Shadow memory is never cleared; the bitmap decides whether its content counts.
    logic [WIDTH-1:0]  mem [SIZE];
    logic [SIZE-1:0]   written;

    // Dump pipeline: fetch = read of idx is issued this cycle,
    // load = read data for idx is ready to be presented as a beat.
    logic [ADDR_W-1:0] idx;
    logic              fetch;
    logic              load;
    logic [WIDTH-1:0]  rd_q;
    logic              rd_bit;

    logic              in_range;
    logic              cap_wr;
    logic              hs;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign dbg_state = state;

    // Decode write qualification and the dump read request.
    always_comb begin
        in_range = ({1'b0, bus.p0_addr_data} < SIZE_L);
        cap_wr   = (state == CAPTURE) && bus.p0_wr_en && in_range;
        hs       = bus.dump_valid && bus.dump_ready;
        // The first read is issued one cycle after dump_start so a write landing
        // with dump_start is already in memory; later reads are issued on the
        // handshake so the next beat is ready after a single idle cycle.
        rd_en    = (state == DUMP) && (fetch || (hs && !bus.dump_last));
        rd_addr  = fetch ? idx : (idx + ADDR_W'(1));
    end

    // Shadow memory: write in CAPTURE, synchronous read during DUMP.
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            mem[bus.p0_addr_data] <= bus.p0_wr_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Control FSM, bitmap, counters, sticky errors and registered dump outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= CAPTURE;
            written        <= '0;
            wr_count       <= '0;
            done           <= 1'b0;
            dup_err        <= 1'b0;
            oob_err        <= 1'b0;
            late_err       <= 1'b0;
            idx            <= '0;
            fetch          <= 1'b0;
            load           <= 1'b0;
            rd_bit         <= 1'b0;
            bus.dump_valid <= 1'b0;
            bus.dump_addr  <= '0;
            bus.dump_data  <= '0;
            bus.dump_last  <= 1'b0;
        end else begin
            // done lags wr_count by one cycle and is sticky.
            done <= done | (wr_count == SIZE_L);

            if (rd_en) begin
                rd_bit <= written[rd_addr];
            end

            case (state)
                CAPTURE: begin
                    if (bus.p0_wr_en) begin
                        if (!in_range) begin
                            oob_err <= 1'b1;
                        end else if (written[bus.p0_addr_data]) begin
                            dup_err <= 1'b1;
                        end else begin
                            written[bus.p0_addr_data] <= 1'b1;
                            wr_count <= wr_count + (ADDR_W+1)'(1);
                        end
                    end
                    if (bus.dump_start) begin
                        state <= DUMP;
                        idx   <= '0;
                        fetch <= 1'b1;
                        load  <= 1'b0;
                    end
                end

                DUMP: begin
                    if (bus.p0_wr_en) begin
                        late_err <= 1'b1;
                    end
                    if (fetch) begin
                        fetch <= 1'b0;
                        load  <= 1'b1;
                    end
                    if (load) begin
                        load           <= 1'b0;
                        bus.dump_valid <= 1'b1;
                        bus.dump_addr  <= idx;
                        bus.dump_data  <= rd_bit ? rd_q : '0;
                        bus.dump_last  <= (idx == LAST_ADDR);
                    end
                    if (hs) begin
                        bus.dump_valid <= 1'b0;
                        if (bus.dump_last) begin
                            bus.dump_last <= 1'b0;
                            state         <= FINISHED;
                        end else begin
                            idx  <= idx + ADDR_W'(1);
                            load <= 1'b1;
                        end
                    end
                end

                FINISHED: begin
                    if (bus.p0_wr_en) begin
                        late_err <= 1'b1;
                    end
                end

                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memref_wr_monitor.sv
// Bench for memref_wr_monitor: directed sequence with randomized data, addresses
// and sink back-pressure, checked against an array/queue reference model.
module tb_memref_wr_monitor;

    localparam int WIDTH  = 32;
    localparam int SIZE   = 1024;
    localparam int ADDR_W = 10;

    localparam int PH_CAPTURE  = 0;
    localparam int PH_DUMP     = 1;
    localparam int PH_FINISHED = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memref_wr_monitor_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              dup_err;
    logic              oob_err;
    logic              late_err;
    logic [1:0]        dbg_state;

    memref_wr_monitor #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .done      (done),
        .wr_count  (wr_count),
        .dup_err   (dup_err),
        .oob_err   (oob_err),
        .late_err  (late_err),
        .dbg_state (dbg_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what the image and status should be, from the write history.
    logic [WIDTH-1:0] m_mem [SIZE];
    bit               m_wr  [SIZE];
    int               m_count;
    bit               m_done, m_dup, m_oob, m_late;
    int               m_phase;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; done follows the count seen before the edge.
    task automatic step();
        bit pend;
        pend = m_done || (m_count == SIZE);
        @(posedge clk);
        #1;
        m_done = pend;
    endtask

    task automatic model_write(input int a, input logic [WIDTH-1:0] d);
        if (m_phase != PH_CAPTURE) m_late = 1'b1;
        else if (a >= SIZE) m_oob = 1'b1;
        else if (m_wr[a]) begin
            m_dup    = 1'b1;
            m_mem[a] = d;
        end else begin
            m_wr[a]  = 1'b1;
            m_mem[a] = d;
            m_count++;
        end
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d);
        bus.p0_wr_en     = 1'b1;
        bus.p0_addr_data = ADDR_W'(a);
        bus.p0_wr_data   = d;
        step();
        bus.p0_wr_en     = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        bus.p0_wr_en   = 1'b0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        step();
        rst     = 1'b1;
        m_count = 0;
        m_done  = 1'b0;
        m_dup   = 1'b0;
        m_oob   = 1'b0;
        m_late  = 1'b0;
        m_phase = PH_CAPTURE;
        for (int i = 0; i < SIZE; i++) m_wr[i] = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_wr_count"}, wr_count, m_count);
        check({tag, "_done"}, done, m_done);
        check({tag, "_dup_err"}, dup_err, m_dup);
        check({tag, "_oob_err"}, oob_err, m_oob);
        check({tag, "_late_err"}, late_err, m_late);
        check({tag, "_state"}, dbg_state, m_phase);
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, "_valid"}, bus.dump_valid, 0);
        check({tag, "_last"}, bus.dump_last, 0);
    endtask

    // Start a dump and consume up to stop_after beats. Optional write alongside
    // dump_start, optional late write to addr 3 once late_at beats are done.
    task automatic run_dump(input bit rand_ready, input int stop_after, input int late_at,
                            input bit wr_with_start, input int ws_addr,
                            input logic [WIDTH-1:0] ws_data, output int cycles);
        int               beats;
        bit               stalled, prev_hs, late_done, rdy, lw;
        logic [ADDR_W-1:0] h_addr;
        logic [WIDTH-1:0]  h_data, lw_data, e_data;
        logic              h_last;
        beats = 0; cycles = 0; stalled = 0; prev_hs = 0; late_done = 0;
        h_addr = '0; h_data = '0; h_last = 1'b0; lw_data = '0;

        bus.dump_start = 1'b1;
        if (wr_with_start) begin
            bus.p0_wr_en     = 1'b1;
            bus.p0_addr_data = ADDR_W'(ws_addr);
            bus.p0_wr_data   = ws_data;
        end
        step();
        bus.dump_start = 1'b0;
        bus.p0_wr_en   = 1'b0;
        if (wr_with_start) model_write(ws_addr, ws_data);
        m_phase = PH_DUMP;
        exp_q.delete();
        for (int k = 0; k < SIZE; k++) exp_q.push_back(m_wr[k] ? m_mem[k] : '0);

        check("start_valid_n", bus.dump_valid, 0);
        check("start_state", dbg_state, PH_DUMP);
        step();
        check("start_valid_n1", bus.dump_valid, 0);
        step();
        check("start_valid_n2", bus.dump_valid, 1);
        check("start_addr_n2", bus.dump_addr, 0);

        while (beats < stop_after && cycles < 20000) begin
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_hs) check("bubble_valid", bus.dump_valid, 0);
            prev_hs = 1'b0;
            if (bus.dump_valid) begin
                if (stalled) begin
                    check("stall_addr", bus.dump_addr, h_addr);
                    check("stall_data", bus.dump_data, h_data);
                    check("stall_last", bus.dump_last, h_last);
                end
                if (rdy) begin
                    e_data = exp_q.pop_front();
                    check("beat_addr", bus.dump_addr, beats);
                    check("beat_data", bus.dump_data, e_data);
                    check("beat_last", bus.dump_last, 64'(beats == SIZE - 1));
                    beats++;
                    stalled = 1'b0;
                    prev_hs = 1'b1;
                end else begin
                    stalled = 1'b1;
                    h_addr  = bus.dump_addr;
                    h_data  = bus.dump_data;
                    h_last  = bus.dump_last;
                end
            end
            bus.dump_ready   = rdy;
            lw               = (beats == late_at) && !late_done;
            lw_data          = $urandom;
            bus.p0_wr_en     = lw;
            bus.p0_addr_data = ADDR_W'(3);
            bus.p0_wr_data   = lw_data;
            bus.dump_start   = (cycles == 7);
            step();
            cycles++;
            if (lw) begin
                model_write(3, lw_data);
                late_done = 1'b1;
            end
        end
        bus.p0_wr_en   = 1'b0;
        bus.dump_ready = 1'b0;
        bus.dump_start = 1'b0;
        check("dump_beats", beats, stop_after);
        if (beats == SIZE) m_phase = PH_FINISHED;
    endtask

    // Guard against a hung run.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int a;
        rst              = 1'b0;
        bus.p0_wr_en     = 1'b0;
        bus.p0_addr_data = '0;
        bus.p0_wr_data   = '0;
        bus.dump_start   = 1'b0;
        bus.dump_ready   = 1'b0;
        m_phase          = PH_CAPTURE;

        // Reset state
        do_reset();
        check_status("reset");
        check_dump_idle("reset");
        check("reset_addr", bus.dump_addr, 0);
        check("reset_data", bus.dump_data, 0);

        // Duplicate write: last write wins, count stays at one
        do_write(5, 7);
        check_status("first_wr");
        do_write(5, 9);
        check_status("dup_wr");
        repeat (40) begin
            a = $urandom_range(10, SIZE - 1);
            do_write(a, $urandom);
        end
        check_status("rand_wr");

        // Dump with random back-pressure
        run_dump(1'b1, SIZE, -1, 1'b0, 0, '0, cyc);
        check_status("dump1_end");
        check_dump_idle("dump1_end");

        // dump_start and writes in FINISHED
        bus.dump_start   = 1'b1;
        bus.p0_wr_en     = 1'b1;
        bus.p0_addr_data = ADDR_W'(7);
        bus.p0_wr_data   = 32'h1234;
        step();
        bus.dump_start = 1'b0;
        bus.p0_wr_en   = 1'b0;
        model_write(7, 32'h1234);
        step();
        step();
        check_status("finished_hold");
        check_dump_idle("finished_hold");

        // Full image, each address once
        do_reset();
        check_status("reset2");
        for (int i = 0; i < SIZE; i++) do_write(i, WIDTH'(i * 3));
        check("full_count", wr_count, SIZE);
        check("full_done_lag", done, 0);
        step();
        check("full_done", done, 1);
        check_status("full");

        // Dump with ready held high: one beat per 2 cycles
        run_dump(1'b0, SIZE, -1, 1'b0, 0, '0, cyc);
        check("dump2_cycles", cyc, 2 * SIZE - 1);
        check_status("dump2_end");
        check_dump_idle("dump2_end");

        // Late write during dump, then reset mid-dump
        do_reset();
        repeat (100) begin
            a = $urandom_range(0, SIZE - 1);
            do_write(a, $urandom);
        end
        run_dump(1'b1, 10, 1, 1'b1, 3, $urandom, cyc);
        check_status("late");
        do_reset();
        check_status("abort_reset");
        check_dump_idle("abort_reset");
        check("abort_addr", bus.dump_addr, 0);
        check("abort_data", bus.dump_data, 0);

        // Fresh capture with nothing written: every beat must be 0
        run_dump(1'b1, SIZE, -1, 1'b0, 0, '0, cyc);
        check_status("empty_end");
        check_dump_idle("empty_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
